// File: rtl/bus32_arbiter.sv
// Round-robin output-enable sequencer for an N-source tri-state bus.
// It grants one owner at a time and inserts one idle turnaround cycle between owners.
module bus32_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] g,
  output logic [N-1:0] gnt,
  output logic         busy
);

  localparam int IDX_W  = $clog2(N);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    last;
  logic [HOLD_W-1:0]   hold;
  logic [N-1:0]        gnt_r;

  logic [IDX_W-1:0]    pick;
  logic [N-1:0]        others;
  logic                hold_full;
  logic                release_bus;

  // Scan last+1, last+2, ... modulo N, so the previous owner is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     r,
                                               input logic [IDX_W-1:0] l);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = l;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(l) + i) % N;
      if (!found && r[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] h);
    if (h >= HOLD_W'(MAX_HOLD))
      return HOLD_W'(MAX_HOLD);
    else
      return h + HOLD_W'(1);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N'(1) << idx;
  endfunction

  always_comb begin
    pick        = rr_pick(req, last);
    others      = req & ~onehot(owner);
    hold_full   = (hold == HOLD_W'(MAX_HOLD));
    release_bus = !req[owner] || (hold_full && (others != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDX_W'(N - 1);
      hold  <= '0;
      gnt_r <= '0;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (req != '0) begin
            state <= DRIVE;
            owner <= pick;
            last  <= pick;
            hold  <= HOLD_W'(1);
            gnt_r <= onehot(pick);
          end else begin
            state <= IDLE;
            gnt_r <= '0;
          end
        end
        DRIVE: begin
          // Dropping the enable here guarantees an all-off cycle before the next owner.
          if (release_bus) begin
            state <= TURN;
            gnt_r <= '0;
          end else begin
            hold <= sat_inc(hold);
          end
        end
        default: begin
          state <= IDLE;
          gnt_r <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_r;
  assign g    = ~gnt_r;
  assign busy = |gnt_r;

endmodule

// File: tb/tb_bus32_arbiter.sv
// Scoreboard bench for bus32_arbiter: directed req/rst vectors push expected g,
// a monitor pops one expectation per rising edge and compares g, gnt and busy.
module tb_bus32_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] g;
  logic [7:0] gnt;
  logic       busy;

  logic [7:0] exp_q[$];
  int         checks;
  int         failures;
  int         cyc;

  bus32_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .g    (g),
    .gnt  (gnt),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the expectation applies after the next rising edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] e);
    @(negedge clk);
    rst = r;
    req = rq;
    exp_q.push_back(e);
  endtask

  task automatic steps(input int n, input logic [7:0] rq, input logic [7:0] e);
    for (int i = 0; i < n; i++) step(1'b0, rq, e);
  endtask

  initial begin : monitor
    logic [7:0] e;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL g cyc=%0d actual=%h expected=%h", cyc, g, e);
        end
        checks++;
        if (gnt !== ~e) begin
          failures++;
          $display("FAIL gnt cyc=%0d actual=%h expected=%h", cyc, gnt, ~e);
        end
        checks++;
        if (busy !== (e != 8'hFF)) begin
          failures++;
          $display("FAIL busy cyc=%0d actual=%b expected=%b", cyc, busy, (e != 8'hFF));
        end
      end
    end
  end

  initial begin : stimulus
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 8'h00;

    // Reset with every source requesting, then source 0 wins first.
    step(1'b1, 8'hFF, 8'hFF);
    step(1'b1, 8'hFF, 8'hFF);
    step(1'b0, 8'hFF, 8'hFE);
    steps(2, 8'h00, 8'hFF);

    // Single uncontended requester keeps the bus past MAX_HOLD.
    steps(10, 8'h08, 8'hF7);
    steps(2, 8'h00, 8'hFF);

    // Contention between sources 0 and 2: forced handoff every 4 cycles.
    steps(4, 8'h05, 8'hFE);
    steps(1, 8'h05, 8'hFF);
    steps(4, 8'h05, 8'hFB);
    steps(1, 8'h05, 8'hFF);
    steps(1, 8'h05, 8'hFE);
    steps(2, 8'h00, 8'hFF);

    // Wrap: own with source 6, then 7 -> 0 -> 6 under req=C1.
    steps(1, 8'h40, 8'hBF);
    steps(1, 8'h00, 8'hFF);
    steps(4, 8'hC1, 8'h7F);
    steps(1, 8'hC1, 8'hFF);
    steps(4, 8'hC1, 8'hFE);
    steps(1, 8'hC1, 8'hFF);
    steps(1, 8'hC1, 8'hBF);
    steps(2, 8'h00, 8'hFF);

    // Voluntary release by owner 2 while source 5 waits.
    steps(2, 8'h24, 8'hFB);
    steps(1, 8'h20, 8'hFF);
    steps(2, 8'h20, 8'hDF);
    steps(2, 8'h00, 8'hFF);

    // Reset mid-drive of source 4; afterwards priority restarts at source 0.
    steps(2, 8'h10, 8'hEF);
    step(1'b1, 8'h12, 8'hFF);
    step(1'b0, 8'h12, 8'hFD);
    steps(2, 8'h00, 8'hFF);

    // Owner re-raises req during the turnaround with nobody else requesting.
    steps(1, 8'h02, 8'hFD);
    steps(1, 8'h00, 8'hFF);
    steps(1, 8'h02, 8'hFD);
    steps(2, 8'h00, 8'hFF);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
